// File: rtl/core_ifu_fq.sv
// Instruction-fetch unit: keeps up to FQ_DEPTH imem requests in flight, buffers
// in-order responses with their PCs and hands them to decode over valid/ready.
module core_ifu_fq #(
    parameter int                 PC_W       = 32,
    parameter int                 INSTR_W    = 32,
    parameter logic [PC_W-1:0]    RESET_PC   = '0,
    parameter int                 FQ_DEPTH   = 4,
    parameter logic [INSTR_W-1:0] HOLD_INSTR = 32'h0000_0073
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_instr,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               id_valid,
    output logic [PC_W-1:0]    id_pc,
    output logic [INSTR_W-1:0] id_instr,
    input  logic               id_ready,
    output logic               halted
);
    localparam int IDX_W = $clog2(FQ_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [PTR_W-1:0]   rd_reg, rd_next;
    logic [PTR_W-1:0]   fill_reg, fill_next;
    logic [PTR_W-1:0]   alloc_reg, alloc_next;
    logic [PTR_W-1:0]   drop_cnt_reg, drop_cnt_next;
    logic               halted_reg, halted_next;

    logic [PC_W-1:0]    entry_pc_reg    [FQ_DEPTH];
    logic [INSTR_W-1:0] entry_instr_reg [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] entry_filled_reg;

    logic [IDX_W-1:0]   rd_idx, fill_idx, alloc_idx;
    logic [PTR_W:0]     credit_used;
    logic               issue_fire, deq_fire, rsp_keep, hold_hit;
    logic [PTR_W-1:0]   alloc_after_issue;
    logic [PTR_W-1:0]   redirect_drop_sum;
    logic [FQ_DEPTH-1:0] alloc_we, fill_we;

    assign rd_idx    = rd_reg[IDX_W-1:0];
    assign fill_idx  = fill_reg[IDX_W-1:0];
    assign alloc_idx = alloc_reg[IDX_W-1:0];

    // Every slot held by a queued entry or an outstanding response (live or
    // to-be-dropped) consumes one credit, so a response always finds a slot.
    assign credit_used = {1'b0, alloc_reg - rd_reg} + {1'b0, drop_cnt_reg};

    assign imem_req_valid = !rst && !halted_reg && !redirect_valid
                            && (credit_used < (PTR_W+1)'(FQ_DEPTH));
    assign imem_req_addr  = pc_reg;

    assign id_valid = (rd_reg != fill_reg) && entry_filled_reg[rd_idx];
    assign id_pc    = id_valid ? entry_pc_reg[rd_idx]    : '0;
    assign id_instr = id_valid ? entry_instr_reg[rd_idx] : '0;
    assign halted   = halted_reg;

    assign issue_fire = imem_req_valid && imem_req_ready;
    assign deq_fire   = id_valid && id_ready;
    assign rsp_keep   = imem_rsp_valid && !redirect_valid && (drop_cnt_reg == '0);
    assign hold_hit   = rsp_keep && (imem_rsp_instr == HOLD_INSTR);

    assign alloc_after_issue = issue_fire ? alloc_reg + PTR_W'(1) : alloc_reg;
    assign redirect_drop_sum = drop_cnt_reg + (alloc_reg - fill_reg);

    genvar gi;
    generate
        for (gi = 0; gi < FQ_DEPTH; gi = gi + 1) begin : g_entry_we
            assign alloc_we[gi] = issue_fire && (alloc_idx == IDX_W'(gi));
            assign fill_we[gi]  = rsp_keep && (fill_idx == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        pc_next       = pc_reg;
        rd_next       = rd_reg;
        fill_next     = fill_reg;
        alloc_next    = alloc_reg;
        drop_cnt_next = drop_cnt_reg;
        halted_next   = halted_reg;
        if (redirect_valid) begin
            // Everything still outstanding becomes a drop; a response arriving
            // this very cycle is one of them and is retired immediately.
            pc_next     = redirect_pc;
            rd_next     = alloc_reg;
            fill_next   = alloc_reg;
            alloc_next  = alloc_reg;
            halted_next = 1'b0;
            if (imem_rsp_valid && (redirect_drop_sum != '0)) begin
                drop_cnt_next = redirect_drop_sum - PTR_W'(1);
            end else begin
                drop_cnt_next = redirect_drop_sum;
            end
        end else begin
            if (issue_fire) begin
                alloc_next = alloc_reg + PTR_W'(1);
                pc_next    = pc_reg + PC_W'(4);
            end
            if (deq_fire) begin
                rd_next = rd_reg + PTR_W'(1);
            end
            if (imem_rsp_valid) begin
                if (drop_cnt_reg != '0) begin
                    drop_cnt_next = drop_cnt_reg - PTR_W'(1);
                end else begin
                    fill_next = fill_reg + PTR_W'(1);
                    if (hold_hit) begin
                        // Squash every younger request, including one issued now.
                        halted_next   = 1'b1;
                        alloc_next    = fill_reg + PTR_W'(1);
                        drop_cnt_next = alloc_after_issue - fill_reg - PTR_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            rd_reg       <= '0;
            fill_reg     <= '0;
            alloc_reg    <= '0;
            drop_cnt_reg <= '0;
            halted_reg   <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            rd_reg       <= rd_next;
            fill_reg     <= fill_next;
            alloc_reg    <= alloc_next;
            drop_cnt_reg <= drop_cnt_next;
            halted_reg   <= halted_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                entry_pc_reg[i]    <= '0;
                entry_instr_reg[i] <= '0;
            end
            entry_filled_reg <= '0;
        end else begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                if (alloc_we[i]) begin
                    entry_pc_reg[i]     <= pc_reg;
                    entry_filled_reg[i] <= 1'b0;
                end
                if (fill_we[i]) begin
                    entry_instr_reg[i]  <= imem_rsp_instr;
                    entry_filled_reg[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_core_ifu_fq.sv
// Randomized bench for core_ifu_fq: a variable-latency imem model drives the DUT
// while a request/queue-level reference model predicts every output each cycle.
module tb_core_ifu_fq;
    localparam int          PC_W     = 32;
    localparam int          INSTR_W  = 32;
    localparam int          FQ_DEPTH = 4;
    localparam logic [31:0] RST_PC   = 32'h0000_0100;
    localparam logic [31:0] HOLD     = 32'h0000_0073;

    logic               clk = 1'b0;
    logic               rst;
    logic               imem_req_valid;
    logic [PC_W-1:0]    imem_req_addr;
    logic               imem_req_ready;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_instr;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               id_valid;
    logic [PC_W-1:0]    id_pc;
    logic [INSTR_W-1:0] id_instr;
    logic               id_ready;
    logic               halted;

    core_ifu_fq #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RST_PC),
        .FQ_DEPTH(FQ_DEPTH), .HOLD_INSTR(HOLD)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_instr(imem_rsp_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_ready(id_ready), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] addr; logic keep; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    mreq_t       imem_q[$];
    req_t        m_out[$];
    ent_t        m_fq[$];
    logic [31:0] m_pc;
    logic        m_halted;

    int          cyc = 0;
    int          lat = 1;
    int          n_issue = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] hold_addr = 32'h1;
    logic        redir_on_hold = 1'b0;
    logic [31:0] hold_redir_pc = '0;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a == hold_addr) return HOLD;
        w = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        if (w == HOLD) w = ~w;
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_instr = '0; id_ready = 1'b0;
        imem_q.delete(); m_out.delete(); m_fq.delete();
        m_pc = RST_PC; m_halted = 1'b0; redir_on_hold = 1'b0;
        repeat (2) @(negedge clk);
        expect_eq("rst_req_valid", imem_req_valid, 0);
        expect_eq("rst_req_addr", imem_req_addr, RST_PC);
        expect_eq("rst_id_valid", id_valid, 0);
        expect_eq("rst_id_pc", id_pc, 0);
        expect_eq("rst_id_instr", id_instr, 0);
        expect_eq("rst_halted", halted, 0);
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance imem and model to the state after the coming rising edge.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy, input logic idr);
        logic        exp_rv, exp_iv, rsp, deq;
        logic [31:0] rsp_addr;
        mreq_t       mr;
        req_t        rq;
        ent_t        en;
        imem_req_ready = rdy;
        id_ready       = idr;
        rsp            = (imem_q.size() > 0) && (imem_q[0].due <= cyc);
        rsp_addr       = rsp ? imem_q[0].addr : 32'h0;
        imem_rsp_valid = rsp;
        imem_rsp_instr = rsp ? mem_word(rsp_addr) : 32'h0;
        if (redir_on_hold && rsp && rsp_addr == hold_addr) begin
            redir = 1'b1; rpc = hold_redir_pc; redir_on_hold = 1'b0;
        end
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        exp_rv = !m_halted && !redir && (m_out.size() + m_fq.size() < FQ_DEPTH);
        exp_iv = m_fq.size() > 0;
        expect_eq("req_valid", imem_req_valid, exp_rv);
        expect_eq("req_addr", imem_req_addr, m_pc);
        expect_eq("id_valid", id_valid, exp_iv);
        expect_eq("id_pc", id_pc, exp_iv ? m_fq[0].pc : 32'h0);
        expect_eq("id_instr", id_instr, exp_iv ? m_fq[0].instr : 32'h0);
        expect_eq("halted", halted, m_halted);

        if (imem_req_valid && rdy) begin
            mr.addr = imem_req_addr; mr.due = cyc + lat;
            imem_q.push_back(mr);
            n_issue++;
        end
        if (rsp) void'(imem_q.pop_front());

        deq = exp_iv && idr;
        if (deq) begin
            $display("[TB] cycle %0d deq pc=%h instr=%h", cyc, m_fq[0].pc, m_fq[0].instr);
            void'(m_fq.pop_front());
        end
        if (redir) begin
            m_fq.delete();
            foreach (m_out[i]) m_out[i].keep = 1'b0;
            if (rsp && m_out.size() > 0) void'(m_out.pop_front());
            m_halted = 1'b0;
            m_pc = rpc;
        end else begin
            if (exp_rv && rdy) begin
                rq.addr = m_pc; rq.keep = 1'b1;
                m_out.push_back(rq);
                m_pc = m_pc + 32'd4;
            end
            if (rsp) begin
                expect_eq("rsp_outstanding", m_out.size() > 0, 1);
                if (m_out.size() > 0) begin
                    rq = m_out.pop_front();
                    if (rq.keep) begin
                        en.pc = rq.addr; en.instr = mem_word(rq.addr);
                        m_fq.push_back(en);
                        if (en.instr == HOLD) begin
                            m_halted = 1'b1;
                            foreach (m_out[i]) m_out[i].keep = 1'b0;
                        end
                    end
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic        r_redir;
        logic [31:0] r_pc;

        // Sequential fetch at full rate with a 1-cycle memory.
        lat = 1; hold_addr = 32'h1;
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Decode stalled: only FQ_DEPTH requests may be accepted.
        do_reset();
        n_issue = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        expect_eq("stall_issue_cnt", n_issue, FQ_DEPTH);
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect with three requests in flight.
        lat = 3;
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Hold instruction at 0x10c, then recovery by redirect.
        hold_addr = 32'h10c;
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        expect_eq("hold_halted", halted, 1);
        step(1'b1, 32'h40, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect landing on the hold response plus a decode handshake.
        lat = 1; hold_addr = 32'h110;
        do_reset();
        redir_on_hold = 1'b1; hold_redir_pc = 32'h300;
        for (int i = 0; i < 14; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        expect_eq("hold_redir_fired", redir_on_hold, 0);

        // Address wrap past the top of the PC space.
        hold_addr = 32'h1;
        step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Random traffic: latency, backpressure, redirects, holds, one reset.
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) lat = $urandom_range(1, 3);
            if (i == 700) do_reset();
            r_redir = ($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 5) == 0);
            r_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if (r_redir) hold_addr = r_pc + 32'd4 * 32'($urandom_range(3, 12));
            step(r_redir, r_pc, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
